// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the front-end pipeline sequencing controller:
// instruction field positions, opcodes of interest and FSM state encodings.
package pipe_ctrl_pkg;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 17;
    localparam int RS2_MSB = 16;
    localparam int RS2_LSB = 12;
    localparam int JR_MSB  = 14;
    localparam int JR_LSB  = 10;

    // Opcodes the controller cares about
    localparam logic [4:0] OP_LD   = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b01101;
    localparam logic [4:0] OP_JPC  = 5'b01110;
    localparam logic [4:0] OP_CALL = 5'b10000;

    // Sequencing FSM states; encodings are visible on state_o
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the load sitting in the
// decode->execute register and the instruction entering fetch->decode.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] if_inst,
    input  logic [DWIDTH-1:0] id_inst,
    output logic              hazard
);

    logic [4:0] id_op;
    logic [4:0] id_rd;
    logic [4:0] if_op;
    logic [4:0] if_rs1;
    logic [4:0] if_rs2;
    logic [4:0] if_jr;
    logic       if_is_jump;
    logic       unused_bits;

    assign id_op  = id_inst[OP_MSB:OP_LSB];
    assign id_rd  = id_inst[RD_MSB:RD_LSB];
    assign if_op  = if_inst[OP_MSB:OP_LSB];
    assign if_rs1 = if_inst[RS1_MSB:RS1_LSB];
    assign if_rs2 = if_inst[RS2_MSB:RS2_LSB];
    assign if_jr  = if_inst[JR_MSB:JR_LSB];

    // Remaining operand/immediate bits play no part in the compare
    assign unused_bits = ^{if_inst, id_inst};

    // Only register-indirect control transfers read the [14:10] field
    assign if_is_jump = (if_op == OP_JR) || (if_op == OP_JPC) || (if_op == OP_CALL);

    // A load into r0 never creates a dependency; a double match is one hazard
    always_comb begin
        hazard = (id_op == OP_LD) && (id_rd != 5'd0) &&
                 ((id_rd == if_rs1) || (id_rd == if_rs2) ||
                  (if_is_jump && (id_rd == if_jr)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the fetch/decode/execute front end.
// Generates PC / fetch->decode / decode->execute enables and flushes for
// load-use stalls, taken-jump flushes and instruction-memory wait states,
// and keeps saturating stall/flush statistics for debug.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DWIDTH       = 32,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CWIDTH       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] if_inst,
    input  logic [DWIDTH-1:0] id_inst,
    input  logic              jump_taken,
    input  logic              imem_ready,
    output logic              pc_en,
    output logic              fd_en,
    output logic              fd_flush,
    output logic              de_en,
    output logic              de_flush,
    output logic [1:0]        state_o,
    output logic [CWIDTH-1:0] stall_cycles,
    output logic [CWIDTH-1:0] flush_events
);

    // The shared down-counter must hold the larger of the two reload values
    localparam int CMAX  = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
    localparam int CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX + 1);

    state_t           state;
    state_t           state_nxt;
    state_t           eff_state;
    state_t           saved_state;
    state_t           saved_state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] eff_cnt;
    logic [CNT_W-1:0] saved_cnt;
    logic [CNT_W-1:0] saved_cnt_nxt;
    logic             hazard;
    logic             stall_inc;
    logic             flush_inc;

    // Statistics counters stick at all-ones instead of wrapping
    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        return (&v) ? v : v + CWIDTH'(1);
    endfunction

    hazard_detect #(
        .DWIDTH (DWIDTH)
    ) u_hazard_detect (
        .if_inst (if_inst),
        .id_inst (id_inst),
        .hazard  (hazard)
    );

    assign state_o = state;

    // Leaving WAIT resumes the interrupted state, evaluated in this same cycle
    always_comb begin
        if (state == ST_WAIT) begin
            eff_state = saved_state;
            eff_cnt   = saved_cnt;
        end else begin
            eff_state = state;
            eff_cnt   = cnt;
        end
    end

    // Control outputs and next-state: jump beats memory wait beats hazard
    always_comb begin
        pc_en           = 1'b1;
        fd_en           = 1'b1;
        fd_flush        = 1'b0;
        de_en           = 1'b1;
        de_flush        = 1'b0;
        state_nxt       = state;
        cnt_nxt         = cnt;
        saved_state_nxt = saved_state;
        saved_cnt_nxt   = saved_cnt;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        if (rst) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else if (jump_taken) begin
            // Squash both younger instructions; aborts any stall or wait
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                state_nxt = ST_FLUSH;
                cnt_nxt   = CNT_W'(FLUSH_CYCLES);
            end else begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        end else if (!imem_ready) begin
            // Freeze everything; remember where we were on first entry only
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            state_nxt = ST_WAIT;
            if (state != ST_WAIT) begin
                saved_state_nxt = state;
                saved_cnt_nxt   = cnt;
            end
        end else begin
            case (eff_state)
                ST_RUN: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = eff_cnt;
                    if (hazard) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        de_flush  = 1'b1;
                        stall_inc = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = ST_STALL;
                            cnt_nxt   = CNT_W'(LOAD_STALL - 1);
                        end
                    end
                end
                ST_STALL: begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    de_flush  = 1'b1;
                    stall_inc = 1'b1;
                    if (eff_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = eff_cnt - CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    fd_flush = 1'b1;
                    if (eff_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_FLUSH;
                        cnt_nxt   = eff_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, shared down-counter, wait context and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            cnt          <= '0;
            saved_state  <= ST_RUN;
            saved_cnt    <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            saved_state <= saved_state_nxt;
            saved_cnt   <= saved_cnt_nxt;
            if (stall_inc) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (flush_inc) begin
                flush_events <= sat_inc(flush_events);
            end
        end
    end

endmodule
